// File: rtl/axi_lite_mem_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out, one response pulse back.
// Optional AXIM_TIMEOUT_EN adds a per-state response-wait limit that completes with SLVERR (2'b10).
module axi_lite_mem_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                mem_axi_aclk,
  input  logic                mem_axi_aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                mem_axi_awvalid,
  input  logic                mem_axi_awready,
  output logic [ADDR_W-1:0]   mem_axi_awaddr,
  output logic                mem_axi_wvalid,
  input  logic                mem_axi_wready,
  output logic [DATA_W-1:0]   mem_axi_wdata,
  output logic [DATA_W/8-1:0] mem_axi_wstrb,
  input  logic                mem_axi_bvalid,
  output logic                mem_axi_bready,
  input  logic [1:0]          mem_axi_bresp,
  output logic                mem_axi_arvalid,
  input  logic                mem_axi_arready,
  output logic [ADDR_W-1:0]   mem_axi_araddr,
  input  logic                mem_axi_rvalid,
  output logic                mem_axi_rready,
  input  logic [DATA_W-1:0]   mem_axi_rdata,
  input  logic [1:0]          mem_axi_rresp,
  output logic [2:0]          dbg_state
);

  // Every channel uses valid/ready: a beat transfers on the rising edge where both are high;
  // valid, once raised, holds with stable payload until that edge.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state;
  logic                aw_done, w_done, hold_write;
  logic [ADDR_W-1:0]   hold_addr;
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                aw_fin, w_fin, hs_leave, tmo_hit;

  assign aw_hs  = mem_axi_awvalid && mem_axi_awready;
  assign w_hs   = mem_axi_wvalid && mem_axi_wready;
  assign b_hs   = mem_axi_bvalid && mem_axi_bready;
  assign ar_hs  = mem_axi_arvalid && mem_axi_arready;
  assign r_hs   = mem_axi_rvalid && mem_axi_rready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  assign mem_axi_awaddr = hold_addr;
  assign mem_axi_araddr = hold_addr;
  assign dbg_state      = state;

  always_comb begin
    hs_leave = 1'b0;
    case (state)
      WR_REQ:  hs_leave = aw_fin && w_fin;
      WR_RESP: hs_leave = b_hs;
      RD_REQ:  hs_leave = ar_hs;
      RD_RESP: hs_leave = r_hs;
      default: hs_leave = 1'b0;
    endcase
  end

`ifdef AXIM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          waiting;

  assign waiting = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_RESP);
  assign tmo_hit = waiting && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Counts cycles spent in the current wait state; restarts on every state change.
  always_ff @(posedge mem_axi_aclk or negedge mem_axi_aresetn) begin
    if (!mem_axi_aresetn) tmo_cnt <= '0;
    else if (!waiting || hs_leave || tmo_hit) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge mem_axi_aclk or negedge mem_axi_aresetn) begin
    if (!mem_axi_aresetn) begin
      state           <= IDLE;
      cmd_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_resp        <= 2'b00;
      mem_axi_awvalid <= 1'b0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_wdata   <= '0;
      mem_axi_wstrb   <= '0;
      mem_axi_bready  <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_rready  <= 1'b0;
      hold_addr       <= '0;
      hold_write      <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
    end else if (tmo_hit && !hs_leave) begin
      mem_axi_awvalid <= 1'b0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_bready  <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_rready  <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      rsp_valid       <= 1'b1;
      rsp_write       <= hold_write;
      rsp_rdata       <= '0;
      rsp_resp        <= 2'b10;
      state           <= DONE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready     <= 1'b0;
            hold_addr     <= cmd_addr;
            hold_write    <= cmd_write;
            mem_axi_wdata <= cmd_wdata;
            mem_axi_wstrb <= cmd_wstrb;
            if (cmd_write) begin
              mem_axi_awvalid <= 1'b1;
              mem_axi_wvalid  <= 1'b1;
              state           <= WR_REQ;
            end else begin
              mem_axi_arvalid <= 1'b1;
              state           <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        // AW and W complete independently; leave only once both have transferred.
        WR_REQ: begin
          if (aw_hs) begin
            mem_axi_awvalid <= 1'b0;
            aw_done         <= 1'b1;
          end
          if (w_hs) begin
            mem_axi_wvalid <= 1'b0;
            w_done         <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            mem_axi_bready <= 1'b1;
            state          <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            mem_axi_bready <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_write      <= 1'b1;
            rsp_rdata      <= '0;
            rsp_resp       <= mem_axi_bresp;
            state          <= DONE;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b1;
            state           <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            mem_axi_rready <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_write      <= 1'b0;
            rsp_rdata      <= mem_axi_rdata;
            rsp_resp       <= mem_axi_rresp;
            state          <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Bench for axi_lite_mem_master: behavioural AXI-Lite slave memory plus a transaction-level response model.
module tb_axi_lite_mem_master;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 64;
  localparam int MEM_WORDS   = 128;
  localparam int W           = 35;

  logic              clk, aresetn;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid, rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [2:0]        dbg_state;

  axi_lite_mem_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .mem_axi_aclk(clk), .mem_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  // ---------------- slave memory (stimulus side) ----------------
  logic [DATA_W-1:0] slave_mem [MEM_WORDS];
  logic              b_hold = 1'b0, slave_flush = 1'b0;
  int                aw_delay = 0, aw_cnt = 0;
  logic              have_aw, have_w, b_pend, r_pend, w_hs_q, aw_hs_q;
  logic [ADDR_W-1:0] s_awaddr;
  logic [DATA_W-1:0] s_wdata, s_rdata;
  logic [3:0]        s_wstrb;
  logic [1:0]        s_bresp, s_rresp;

  initial for (int i = 0; i < MEM_WORDS; i++) slave_mem[i] = 2 * i;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn || slave_flush) begin
      have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0; w_hs_q = 0; aw_hs_q = 0;
    end else begin
      aw_hs_q = awvalid && awready;
      w_hs_q  = wvalid && wready;
      if (aw_hs_q) begin have_aw = 1; s_awaddr = awaddr; end
      if (w_hs_q) begin have_w = 1; s_wdata = wdata; s_wstrb = wstrb; end
      if (bvalid && bready) b_pend = 0;
      if (have_aw && have_w) begin
        if (s_awaddr < MEM_WORDS) begin
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) slave_mem[s_awaddr[6:0]][8*b +: 8] = s_wdata[8*b +: 8];
          s_bresp = 2'b00;
        end else s_bresp = 2'b11;
        b_pend = 1; have_aw = 0; have_w = 0;
      end
      if (rvalid && rready) r_pend = 0;
      if (arvalid && arready) begin
        r_pend  = 1;
        s_rdata = (araddr < MEM_WORDS) ? slave_mem[araddr[6:0]] : '0;
        s_rresp = (araddr < MEM_WORDS) ? 2'b00 : 2'b11;
      end
    end
  end

  always @(negedge clk or negedge aresetn) begin
    if (!aresetn) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0; aw_cnt = 0;
    end else begin
      awready = awvalid && !have_aw && (aw_cnt >= aw_delay);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid && !have_w;
      bvalid  = b_pend && !b_hold;
      bresp   = s_bresp;
      arready = arvalid && !r_pend;
      rvalid  = r_pend;
      rdata   = s_rdata;
      rresp   = s_rresp;
    end
  end

  // ---------------- scoreboard and model ----------------
  int                n_checks = 0, n_errors = 0;
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [DATA_W-1:0] cur_wdata = '0;
  logic [3:0]        cur_wstrb = '0;
  logic [W-1:0]      last_rsp = '0;
  int                last_rsp_cyc = 0, acc_cyc = 0;
  logic              prev_rsp = 1'b0;

  initial for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 2 * i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Whole-transaction view: writes land in the word map, reads return it, out-of-range gives DECERR.
  task automatic model_push(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic tmo);
    logic in_range;
    in_range = (a < MEM_WORDS);
    if (wr && in_range)
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[6:0]][8*b +: 8] = d[8*b +: 8];
    if (tmo)        exp_q.push_back({wr, 32'h0, 2'b10});
    else if (wr)    exp_q.push_back({1'b1, 32'h0, in_range ? 2'b00 : 2'b11});
    else            exp_q.push_back({1'b0, in_range ? ref_mem[a[6:0]] : 32'h0, in_range ? 2'b00 : 2'b11});
  endtask

  always @(negedge clk) begin
    if (aresetn) begin
      if (rsp_valid) begin
        check("rsp_single_pulse", prev_rsp, 0);
        check("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rsp", {rsp_write, rsp_rdata, rsp_resp}, exp_q.pop_front());
        last_rsp     = {rsp_write, rsp_rdata, rsp_resp};
        last_rsp_cyc = cyc;
      end
      if (awvalid) check("awaddr_stable", awaddr, cur_addr);
      if (wvalid)  check("wdata_stable", {wdata, wstrb}, {cur_wdata, cur_wstrb});
      if (arvalid) check("araddr_stable", araddr, cur_addr);
      if (w_hs_q)  check("wvalid_drop", wvalid, 0);
      if (aw_hs_q) check("awvalid_drop", awvalid, 0);
    end
    prev_rsp = aresetn && rsp_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic tmo);
    int n;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    check("cmd_accept", cmd_ready, 1);
    if (cmd_ready) begin
      acc_cyc = cyc;
      cur_addr = a; cur_wdata = d; cur_wstrb = s;
      model_push(wr, a, d, s, tmo);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("rsp_wait_bound", exp_q.size(), 0);
    @(negedge clk);
  endtask

  logic [31:0] tbl_addr [4] = '{32'd40, 32'd41, 32'd127, 32'd0};
  logic [31:0] tbl_data [4] = '{32'h01020304, 32'hA0B0C0D0, 32'hFFFF0000, 32'h89ABCDEF};
  logic [3:0]  tbl_strb [4] = '{4'hF, 4'h3, 4'hC, 4'h8};

  initial begin
    int n;
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 0);
    @(negedge clk);
    aresetn = 1;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    issue(0, 7, 0, 0, 0); wait_rsp();
    check("read7_literal", last_rsp, {1'b0, 32'h0000000E, 2'b00});
    check("read_latency", last_rsp_cyc - acc_cyc, 3);

    issue(1, 5, 32'hDEADBEEF, 4'hF, 0); wait_rsp();
    check("write5_literal", last_rsp, {1'b1, 32'h0, 2'b00});
    check("write_latency", last_rsp_cyc - acc_cyc, 3);
    issue(0, 5, 0, 0, 0); wait_rsp();
    check("read5_literal", last_rsp, {1'b0, 32'hDEADBEEF, 2'b00});

    issue(1, 3, 32'h11223344, 4'b0101, 0); wait_rsp();
    issue(0, 3, 0, 0, 0); wait_rsp();
    check("read3_strobe_literal", last_rsp, {1'b0, 32'h00220044, 2'b00});

    issue(0, 200, 0, 0, 0); wait_rsp();
    check("read200_literal", last_rsp, {1'b0, 32'h0, 2'b11});
    issue(1, 200, 32'hFFFFFFFF, 4'hF, 0); wait_rsp();
    check("write200_literal", last_rsp, {1'b1, 32'h0, 2'b11});
    issue(0, 72, 0, 0, 0); wait_rsp();
    check("read72_untouched", last_rsp, {1'b0, 32'h00000090, 2'b00});

    aw_delay = 3;
    issue(1, 10, 32'hA5A50F0F, 4'hF, 0); wait_rsp();
    check("aw_delay_latency", last_rsp_cyc - acc_cyc, 6);
    aw_delay = 0;
    issue(0, 10, 0, 0, 0); wait_rsp();
    check("read10_literal", last_rsp, {1'b0, 32'hA5A50F0F, 2'b00});

    // Back-to-back commands: each next command waits on cmd_ready.
    for (int i = 0; i < 4; i++) issue(1, tbl_addr[i], tbl_data[i], tbl_strb[i], 0);
    for (int i = 0; i < 4; i++) issue(0, tbl_addr[i], 0, 0, 0);
    wait_rsp();
    check("read0_literal", last_rsp, {1'b0, 32'h89000000, 2'b00});

    // Reset while waiting for B: everything drops at once, no response issued.
    b_hold = 1;
    issue(1, 20, 32'hCAFEF00D, 4'hF, 0);
    n = 0;
    while (!bready && n < 20) begin @(negedge clk); n++; end
    check("reach_wr_resp", bready, 1);
    #2 aresetn = 0;
    #1 check("async_reset_drop", {awvalid, wvalid, bready, rsp_valid, cmd_ready}, 0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    b_hold = 0; aresetn = 1;
    @(negedge clk);
    check("cmd_ready_after_abort", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("no_rsp_after_abort", last_rsp, {1'b0, 32'h89000000, 2'b00});
    issue(0, 20, 0, 0, 0); wait_rsp();
    check("read20_literal", last_rsp, {1'b0, 32'hCAFEF00D, 2'b00});

`ifdef AXIM_TIMEOUT_EN
    b_hold = 1;
    issue(1, 30, 32'h55AA55AA, 4'hF, 1); wait_rsp();
    check("timeout_literal", last_rsp, {1'b1, 32'h0, 2'b10});
    check("timeout_window", (last_rsp_cyc - acc_cyc >= TIMEOUT_CYC) &&
                            (last_rsp_cyc - acc_cyc <= TIMEOUT_CYC + 3), 1);
    slave_flush = 1; @(negedge clk); slave_flush = 0; b_hold = 0;
    issue(0, 30, 0, 0, 0); wait_rsp();
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
